sync_fifo_prog: RTL and testbench

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 129 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds, error pulses/stickies and optional FWFT read.
// Define SYNC_FIFO_HWM_EN to enable the high-water-mark tracker; otherwise hwm is tied to 0.
module sync_fifo_prog #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    parameter int FWFT   = 0,
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             err_clr,
    input  logic             hwm_clr,
    output logic [WIDTH-1:0] rd_data,
    output logic             wr_ack,
    output logic             overflow,
    output logic             underflow,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [LW-1:0]    level,
    output logic [LW-1:0]    hwm
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] rd_q;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_cond;
    logic             udf_cond;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full         = (level == LW'(DEPTH));
    assign empty        = (level == '0);
    assign almost_full  = (level >= LW'(AF_LVL));
    assign almost_empty = (level <= LW'(AE_LVL));

    assign wr_acc   = wr_en && !full;
    assign rd_acc   = rd_en && !empty;
    assign ovf_cond = wr_en && full;
    // A read paired with a write at empty is simply not served yet; only a lone read at empty is an error.
    assign udf_cond = rd_en && empty && !wr_en;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            rd_q       <= '0;
            wr_ack     <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            ovf_sticky <= 1'b0;
            udf_sticky <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
                rd_q   <= mem[rd_ptr];
            end
            if (wr_acc && !rd_acc) begin
                level <= level + LW'(1);
            end else if (rd_acc && !wr_acc) begin
                level <= level - LW'(1);
            end
            wr_ack    <= wr_acc;
            overflow  <= ovf_cond;
            underflow <= udf_cond;
            if (ovf_cond) begin
                ovf_sticky <= 1'b1;
            end else if (err_clr) begin
                ovf_sticky <= 1'b0;
            end
            if (udf_cond) begin
                udf_sticky <= 1'b1;
            end else if (err_clr) begin
                udf_sticky <= 1'b0;
            end
        end
    end

    // In FWFT mode rd_q holds the last popped head, which is what an empty FIFO keeps showing.
    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = empty ? rd_q : mem[rd_ptr];
        end else begin : g_reg
            assign rd_data = rd_q;
        end
    endgenerate

`ifdef SYNC_FIFO_HWM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwm <= '0;
        end else if (hwm_clr) begin
            hwm <= level;
        end else if (level > hwm) begin
            hwm <= level;
        end
    end
`else
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm            = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog: a DEPTH=5 registered-read instance driven from a
// vector table plus corner sequences, and a DEPTH=4 FWFT instance for the fall-through behaviour.
module tb_sync_fifo_prog;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0, hwm_clr = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic [W-1:0]  rd_data;
    logic          wr_ack, overflow, underflow, ovf_sticky, udf_sticky;
    logic          full, empty, almost_full, almost_empty;
    logic [2:0]    level, hwm;

    logic          f_wr_en = 1'b0, f_rd_en = 1'b0;
    logic [W-1:0]  f_wr_data = '0;
    logic [W-1:0]  f_rd_data;
    logic          f_wr_ack, f_overflow, f_underflow, f_ovf_sticky, f_udf_sticky;
    logic          f_full, f_empty, f_almost_full, f_almost_empty;
    logic [2:0]    f_level, f_hwm;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.WIDTH(W), .DEPTH(5), .FWFT(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .err_clr(err_clr), .hwm_clr(hwm_clr), .rd_data(rd_data), .wr_ack(wr_ack),
        .overflow(overflow), .underflow(underflow), .ovf_sticky(ovf_sticky),
        .udf_sticky(udf_sticky), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .level(level), .hwm(hwm)
    );

    sync_fifo_prog #(.WIDTH(W), .DEPTH(4), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .err_clr(1'b0), .hwm_clr(1'b0), .rd_data(f_rd_data), .wr_ack(f_wr_ack),
        .overflow(f_overflow), .underflow(f_underflow), .ovf_sticky(f_ovf_sticky),
        .udf_sticky(f_udf_sticky), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .level(f_level), .hwm(f_hwm)
    );

    typedef struct {
        logic         wr;
        logic [W-1:0] din;
        logic         rd;
        logic         clr;
        int           lvl;
        logic         full;
        logic         empty;
        logic         af;
        logic         ae;
        logic [W-1:0] dout;
        logic         ack;
        logic         ovf;
        logic         udf;
        logic         ovs;
        logic         uds;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus on the DEPTH=5 instance; outputs are sampled 1ns after the edge.
    task automatic applyStimulus(input logic wr, input logic [W-1:0] din, input logic rd,
                                 input logic eclr, input logic hclr);
        wr_en   = wr;
        wr_data = din;
        rd_en   = rd;
        err_clr = eclr;
        hwm_clr = hclr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        hwm_clr = 1'b0;
    endtask

    task automatic applyFwft(input logic wr, input logic [W-1:0] din, input logic rd);
        f_wr_en   = wr;
        f_wr_data = din;
        f_rd_en   = rd;
        @(posedge clk);
        #1;
        f_wr_en = 1'b0;
        f_rd_en = 1'b0;
    endtask

    initial begin
        int exp_hwm;
        //             wr   din     rd  clr lvl full e  af ae dout    ack ovf udf ovs uds
        vecs.push_back('{1, 16'h11, 0, 0, 1, 0, 0, 0, 1, 16'h00, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h22, 0, 0, 2, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h33, 0, 0, 3, 0, 0, 0, 0, 16'h00, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h44, 0, 0, 4, 0, 0, 1, 0, 16'h00, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h55, 0, 0, 5, 1, 0, 1, 0, 16'h00, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h66, 0, 0, 5, 1, 0, 1, 0, 16'h00, 0, 1, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 4, 0, 0, 1, 0, 16'h11, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 3, 0, 0, 0, 0, 16'h22, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 2, 0, 0, 0, 0, 16'h33, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 1, 0, 0, 0, 1, 16'h44, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 0, 0, 1, 0, 1, 16'h55, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 0, 0, 1, 0, 1, 16'h55, 0, 0, 1, 1, 1});
        vecs.push_back('{1, 16'h77, 1, 0, 1, 0, 0, 0, 1, 16'h55, 1, 0, 0, 1, 1});
        vecs.push_back('{0, 16'h00, 0, 1, 1, 0, 0, 0, 1, 16'h55, 0, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h88, 0, 0, 2, 0, 0, 0, 0, 16'h55, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'h99, 0, 0, 3, 0, 0, 0, 0, 16'h55, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'hAA, 0, 0, 4, 0, 0, 1, 0, 16'h55, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'hBB, 0, 0, 5, 1, 0, 1, 0, 16'h55, 1, 0, 0, 0, 0});
        vecs.push_back('{1, 16'hCC, 1, 0, 4, 0, 0, 1, 0, 16'h77, 0, 1, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 3, 0, 0, 0, 0, 16'h88, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 2, 0, 0, 0, 0, 16'h99, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 1, 0, 0, 0, 1, 16'hAA, 0, 0, 0, 1, 0});
        vecs.push_back('{1, 16'hDD, 1, 0, 1, 0, 0, 0, 1, 16'hBB, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 0, 0, 0, 1, 0, 1, 16'hDD, 0, 0, 0, 1, 0});
        vecs.push_back('{0, 16'h00, 1, 1, 0, 0, 1, 0, 1, 16'hDD, 0, 0, 1, 0, 1});

        // Reset state of both instances
        #12;
        checkOutput("rst.level", 32'(level), 0);
        checkOutput("rst.empty", 32'(empty), 1);
        checkOutput("rst.full", 32'(full), 0);
        checkOutput("rst.almost_empty", 32'(almost_empty), 1);
        checkOutput("rst.rd_data", 32'(rd_data), 0);
        checkOutput("rst.flags", {29'd0, wr_ack, overflow, underflow}, 0);
        checkOutput("rst.stickies", {30'd0, ovf_sticky, udf_sticky}, 0);
        checkOutput("rst.hwm", 32'(hwm), 0);
        checkOutput("rst.f_empty", 32'(f_empty), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].clr, 1'b0);
            checkOutput($sformatf("v%0d.level", i), 32'(level), 32'(vecs[i].lvl));
            checkOutput($sformatf("v%0d.full", i), 32'(full), 32'(vecs[i].full));
            checkOutput($sformatf("v%0d.empty", i), 32'(empty), 32'(vecs[i].empty));
            checkOutput($sformatf("v%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].af));
            checkOutput($sformatf("v%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
            checkOutput($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].dout));
            checkOutput($sformatf("v%0d.wr_ack", i), 32'(wr_ack), 32'(vecs[i].ack));
            checkOutput($sformatf("v%0d.overflow", i), 32'(overflow), 32'(vecs[i].ovf));
            checkOutput($sformatf("v%0d.underflow", i), 32'(underflow), 32'(vecs[i].udf));
            checkOutput($sformatf("v%0d.ovf_sticky", i), 32'(ovf_sticky), 32'(vecs[i].ovs));
            checkOutput($sformatf("v%0d.udf_sticky", i), 32'(udf_sticky), 32'(vecs[i].uds));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // Twelve write/read pairs walk both pointers around the 5-entry ring more than twice
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, W'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("wrap%0d.ack", i), 32'(wr_ack), 1);
            checkOutput($sformatf("wrap%0d.level_w", i), 32'(level), 1);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
            checkOutput($sformatf("wrap%0d.rd_data", i), 32'(rd_data), 32'(16'h0100 + i));
            checkOutput($sformatf("wrap%0d.level_r", i), 32'(level), 0);
            checkOutput($sformatf("wrap%0d.flags", i),
                        {28'd0, overflow, underflow, ovf_sticky, udf_sticky}, 0);
        end

        // Asynchronous reset at level 3 takes effect before the next clock edge
        applyStimulus(1'b1, 16'hE1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hE2, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hE3, 1'b0, 1'b0, 1'b0);
        checkOutput("mid.level_pre", 32'(level), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("mid.level", 32'(level), 0);
        checkOutput("mid.empty", 32'(empty), 1);
        checkOutput("mid.rd_data", 32'(rd_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 16'h77, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("mid.first_read", 32'(rd_data), 32'h77);
        checkOutput("mid.empty_after", 32'(empty), 1);

        // High-water mark: fill to 4, drain to 1, then clear to the current level
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        checkOutput("hwm.level", 32'(level), 1);
`ifdef SYNC_FIFO_HWM_EN
        exp_hwm = 4;
`else
        exp_hwm = 0;
`endif
        checkOutput("hwm.peak", 32'(hwm), 32'(exp_hwm));
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
`ifdef SYNC_FIFO_HWM_EN
        exp_hwm = 1;
`else
        exp_hwm = 0;
`endif
        checkOutput("hwm.cleared", 32'(hwm), 32'(exp_hwm));

        // FWFT instance: head appears without a read, pop advances, empty holds last head
        applyFwft(1'b1, 16'hA5, 1'b0);
        checkOutput("fwft.head", 32'(f_rd_data), 32'hA5);
        checkOutput("fwft.empty0", 32'(f_empty), 0);
        applyFwft(1'b0, '0, 1'b1);
        checkOutput("fwft.empty1", 32'(f_empty), 1);
        checkOutput("fwft.hold", 32'(f_rd_data), 32'hA5);
        applyFwft(1'b1, 16'h01, 1'b0);
        applyFwft(1'b1, 16'h02, 1'b0);
        checkOutput("fwft.head2", 32'(f_rd_data), 32'h01);
        applyFwft(1'b0, '0, 1'b1);
        checkOutput("fwft.next", 32'(f_rd_data), 32'h02);
        checkOutput("fwft.level", 32'(f_level), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
